// File: rtl/br_pkg.sv
// Shared constants and types for EX-stage branch resolution and the
// 2-bit branch history table.
package br_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef logic [1:0] bht_cnt_t;

   localparam bht_cnt_t BHT_SNT = 2'b00;
   localparam bht_cnt_t BHT_WNT = 2'b01;
   localparam bht_cnt_t BHT_WT  = 2'b10;
   localparam bht_cnt_t BHT_ST  = 2'b11;

   // Saturating step of a 2-bit direction counter.
   function automatic bht_cnt_t bhtNext(input bht_cnt_t cnt, input logic taken);
      bht_cnt_t nxt;
      nxt = cnt;
      if (taken && cnt != BHT_ST) begin
         nxt = cnt + 2'd1;
      end else if (!taken && cnt != BHT_SNT) begin
         nxt = cnt - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bht_2bit.sv
// Array of 2-bit saturating direction counters with a combinational read
// port for IF and a synchronous training port from EX.
module bht_2bit
   import br_pkg::*;
#(
   parameter int       IDX_W = 6,
   parameter bht_cnt_t INIT  = BHT_WNT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [IDX_W-1:0] rd_idx_i,
   output bht_cnt_t         rd_cnt_o,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i
);

   localparam int ENTRIES = 1 << IDX_W;

   bht_cnt_t r_cnt [ENTRIES];

   // No write-to-read bypass: a same-cycle read sees the pre-update count.
   assign rd_cnt_o = r_cnt[rd_idx_i];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_cnt[i] <= INIT;
         end
      end else if (upd_en_i) begin
         r_cnt[upd_idx_i] <= bhtNext(r_cnt[upd_idx_i], upd_taken_i);
      end
   end

endmodule

// File: rtl/br_resolve_bht.sv
// EX-stage branch/jump resolution: outcome, target, mispredict detection,
// registered redirect/flush, performance counters and BHT training.
module br_resolve_bht
   import br_pkg::*;
#(
   parameter int       BHT_IDX_W = 6,
   parameter bht_cnt_t BHT_INIT  = BHT_WNT
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        ex_valid_i,
   input  logic        ex_stall_i,
   input  logic        ex_is_branch_i,
   input  logic        ex_is_jal_i,
   input  logic        ex_is_jalr_i,
   input  logic [2:0]  ex_funct3_i,
   input  logic [31:0] ex_pc_i,
   input  logic [31:0] ex_imm_i,
   input  logic [31:0] ex_rs1_data_i,
   input  logic [31:0] ex_pred_pc_i,
   input  logic        br_less_i,
   input  logic        br_equal_i,
   output logic        br_unsigned_o,
   input  logic [31:0] if_pc_i,
   output logic        if_pred_taken_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   output logic        flush_o,
   output logic [31:0] perf_br_cnt_o,
   output logic [31:0] perf_mispred_cnt_o
);

   logic        r_redirValid;
   logic [31:0] r_redirPc;
   logic [31:0] r_brCnt;
   logic [31:0] r_misCnt;

   logic        w_resolve;
   logic        w_isJalr;
   logic        w_isJal;
   logic        w_isBr;
   logic        w_legalF3;
   logic        w_condTaken;
   logic        w_taken;
   logic        w_mispredict;
   logic        w_bhtUpd;
   logic [31:0] w_jalrSum;
   logic [31:0] w_target;
   logic [31:0] w_correctPc;
   bht_cnt_t    w_rdCnt;
   logic        w_unused;

   // The instruction sitting in EX during a redirect cycle is wrong-path.
   assign w_resolve = ex_valid_i & ~ex_stall_i & ~r_redirValid;

   assign w_isJalr = ex_is_jalr_i;
   assign w_isJal  = ex_is_jal_i & ~ex_is_jalr_i;
   assign w_isBr   = ex_is_branch_i & ~ex_is_jal_i & ~ex_is_jalr_i;

   always_comb begin
      w_legalF3   = 1'b1;
      w_condTaken = 1'b0;
      case (ex_funct3_i)
         F3_BEQ:          w_condTaken = br_equal_i;
         F3_BNE:          w_condTaken = ~br_equal_i;
         F3_BLT, F3_BLTU: w_condTaken = br_less_i;
         F3_BGE, F3_BGEU: w_condTaken = ~br_less_i;
         default:         w_legalF3   = 1'b0;
      endcase
   end

   assign w_jalrSum   = ex_rs1_data_i + ex_imm_i;
   assign w_target    = w_isJalr ? {w_jalrSum[31:1], 1'b0} : (ex_pc_i + ex_imm_i);
   assign w_taken     = w_isJalr | w_isJal | (w_isBr & w_legalF3 & w_condTaken);
   assign w_correctPc = w_taken ? w_target : (ex_pc_i + 32'd4);

   assign w_mispredict = w_resolve & (w_isJalr | w_isJal | w_isBr) &
                         (w_correctPc != ex_pred_pc_i);
   assign w_bhtUpd     = w_resolve & w_isBr & w_legalF3;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_redirValid <= 1'b0;
         r_redirPc    <= 32'd0;
         r_brCnt      <= 32'd0;
         r_misCnt     <= 32'd0;
      end else begin
         r_redirValid <= w_mispredict;
         if (w_mispredict) begin
            r_redirPc <= w_correctPc;
            r_misCnt  <= r_misCnt + 32'd1;
         end
         if (w_bhtUpd) begin
            r_brCnt <= r_brCnt + 32'd1;
         end
      end
   end

   bht_2bit #(
      .IDX_W (BHT_IDX_W),
      .INIT  (BHT_INIT)
   ) u_bht (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .rd_idx_i    (if_pc_i[BHT_IDX_W+1:2]),
      .rd_cnt_o    (w_rdCnt),
      .upd_en_i    (w_bhtUpd),
      .upd_idx_i   (ex_pc_i[BHT_IDX_W+1:2]),
      .upd_taken_i (w_condTaken)
   );

   assign w_unused = ^{if_pc_i[31:BHT_IDX_W+2], if_pc_i[1:0], w_rdCnt[0]};

   assign br_unsigned_o      = ex_funct3_i[1];
   assign if_pred_taken_o    = w_rdCnt[1];
   assign redirect_valid_o   = r_redirValid;
   assign redirect_pc_o      = r_redirPc;
   assign flush_o            = r_redirValid;
   assign perf_br_cnt_o      = r_brCnt;
   assign perf_mispred_cnt_o = r_misCnt;

endmodule
